// File: rtl/hazard_tracker_pkg.sv
// Shared constants for the hazard tracker.
//  - Tnew values as produced by the decoder for the E stage.
//  - Forwarding-select encodings used by every operand mux.
package hazard_tracker_pkg;

    // Tnew at E entry
    localparam int PC_T  = 0;   // result ready immediately (jal link value)
    localparam int ALU_T = 1;   // result ready at end of E
    localparam int DM_T  = 2;   // result ready at end of M (loads)

    // Forwarding selects
    localparam logic [1:0] FWD_RF = 2'd0;  // use the pipeline/register-file value
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

endpackage

// File: rtl/hazard_tracker_if.sv
// Decoder <-> hazard tracker bundle.
//  master: decoder side, drives the D-stage Tuse/Tnew/A3 fields, reads stall/selects.
//  slave : hazard tracker, reads the D-stage fields, drives stall, selects, stall_cnt.
interface hazard_tracker_if #(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 3,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] D_rs;
    logic [REG_AW-1:0] D_rt;
    logic              D_tuse_rs0;
    logic              D_tuse_rs1;
    logic              D_tuse_rt0;
    logic              D_tuse_rt1;
    logic              D_tuse_rt2;
    logic [REG_AW-1:0] D_A3;
    logic [TNEW_W-1:0] D_tnew;
    logic              stall;
    logic [1:0]        fwd_D_rs;
    logic [1:0]        fwd_D_rt;
    logic [1:0]        fwd_E_rs;
    logic [1:0]        fwd_E_rt;
    logic [1:0]        fwd_M_rt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output D_rs, D_rt, D_tuse_rs0, D_tuse_rs1, D_tuse_rt0, D_tuse_rt1,
               D_tuse_rt2, D_A3, D_tnew,
        input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs0, D_tuse_rs1, D_tuse_rt0, D_tuse_rt1,
               D_tuse_rt2, D_A3, D_tnew,
        output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, stall_cnt
    );
endinterface

// File: rtl/hazard_tracker_hz_match.sv
// hz_match: hazard check for one D-stage source operand.
//  op_i      operand register number
//  use_i     operand is read by this instruction
//  tuse_i    cycles until the operand is needed (0..2)
//  e_*/m_*   E and M record destination and remaining Tnew
//  w_a3_i    W record destination (its Tnew is always 0)
//  stall_o   operand not ready in time
//  fwd_o     D-stage forwarding select
module hz_match
    import hazard_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 3
) (
    input  logic [REG_AW-1:0] op_i,
    input  logic              use_i,
    input  logic [1:0]        tuse_i,
    input  logic [REG_AW-1:0] e_a3_i,
    input  logic [TNEW_W-1:0] e_tnew_i,
    input  logic [REG_AW-1:0] m_a3_i,
    input  logic [TNEW_W-1:0] m_tnew_i,
    input  logic [REG_AW-1:0] w_a3_i,
    output logic              stall_o,
    output logic [1:0]        fwd_o
);
    logic              e_hit, m_hit, w_hit;
    logic [TNEW_W-1:0] tuse_ext;

    // $0 never hits: a zero destination means "no write"
    assign e_hit    = (e_a3_i != '0) && (e_a3_i == op_i);
    assign m_hit    = (m_a3_i != '0) && (m_a3_i == op_i);
    assign w_hit    = (w_a3_i != '0) && (w_a3_i == op_i);
    assign tuse_ext = TNEW_W'(tuse_i);

    // Only the nearest matching stage decides both stall and select
    always_comb begin
        stall_o = 1'b0;
        fwd_o   = FWD_RF;
        if (e_hit) begin
            stall_o = use_i && (e_tnew_i > tuse_ext);
            fwd_o   = (e_tnew_i == '0) ? FWD_E : FWD_RF;
        end else if (m_hit) begin
            stall_o = use_i && (m_tnew_i > tuse_ext);
            fwd_o   = (m_tnew_i == '0) ? FWD_M : FWD_RF;
        end else if (w_hit) begin
            fwd_o   = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: E/M/W destination records, D-stage stall, D/E/M forwarding
// selects and a saturating stall-cycle counter.
//  clk    rising-edge clock
//  reset  asynchronous, active-low
//  bus    hazard_tracker_if.slave (D-stage fields in; stall, selects, stall_cnt out)
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_tracker_if.slave        bus
);
    logic [REG_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_a3_q, e_a3_d;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
    logic [REG_AW-1:0] m_rt_q, m_rt_d, m_a3_q, m_a3_d;
    logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
    logic [REG_AW-1:0] w_a3_q, w_a3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       rs_use, rt_use, rs_stall, rt_stall, stall;
    logic [1:0] rs_tuse, rt_tuse;
    logic [1:0] fwd_e_rs, fwd_e_rt, fwd_m_rt;

    // Earliest need wins when several Tuse flags are set
    assign rs_use  = bus.D_tuse_rs0 | bus.D_tuse_rs1;
    assign rs_tuse = bus.D_tuse_rs0 ? 2'd0 : 2'd1;
    assign rt_use  = bus.D_tuse_rt0 | bus.D_tuse_rt1 | bus.D_tuse_rt2;
    assign rt_tuse = bus.D_tuse_rt0 ? 2'd0 : (bus.D_tuse_rt1 ? 2'd1 : 2'd2);

    hz_match #(.REG_AW(REG_AW), .TNEW_W(TNEW_W)) u_rs (
        .op_i(bus.D_rs), .use_i(rs_use), .tuse_i(rs_tuse),
        .e_a3_i(e_a3_q), .e_tnew_i(e_tnew_q), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q),
        .w_a3_i(w_a3_q), .stall_o(rs_stall), .fwd_o(bus.fwd_D_rs)
    );

    hz_match #(.REG_AW(REG_AW), .TNEW_W(TNEW_W)) u_rt (
        .op_i(bus.D_rt), .use_i(rt_use), .tuse_i(rt_tuse),
        .e_a3_i(e_a3_q), .e_tnew_i(e_tnew_q), .m_a3_i(m_a3_q), .m_tnew_i(m_tnew_q),
        .w_a3_i(w_a3_q), .stall_o(rt_stall), .fwd_o(bus.fwd_D_rt)
    );

    assign stall = rs_stall | rt_stall;

    // E operands look at M then W; M store data looks at W only
    always_comb begin
        fwd_e_rs = FWD_RF;
        fwd_e_rt = FWD_RF;
        fwd_m_rt = FWD_RF;
        if (m_a3_q != '0 && m_a3_q == e_rs_q)
            fwd_e_rs = (m_tnew_q == '0) ? FWD_M : FWD_RF;
        else if (w_a3_q != '0 && w_a3_q == e_rs_q)
            fwd_e_rs = FWD_W;
        if (m_a3_q != '0 && m_a3_q == e_rt_q)
            fwd_e_rt = (m_tnew_q == '0) ? FWD_M : FWD_RF;
        else if (w_a3_q != '0 && w_a3_q == e_rt_q)
            fwd_e_rt = FWD_W;
        if (w_a3_q != '0 && w_a3_q == m_rt_q)
            fwd_m_rt = FWD_W;
    end

    // Next-state: a stalled D instruction enters E as an all-zero bubble
    always_comb begin
        e_rs_d   = stall ? '0 : bus.D_rs;
        e_rt_d   = stall ? '0 : bus.D_rt;
        e_a3_d   = stall ? '0 : bus.D_A3;
        e_tnew_d = stall ? '0 : bus.D_tnew;
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
        w_a3_d   = m_a3_q;
        cnt_d    = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            m_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
            cnt_q    <= '0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= m_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd_E_rs  = fwd_e_rs;
    assign bus.fwd_E_rt  = fwd_e_rt;
    assign bus.fwd_M_rt  = fwd_m_rt;
    assign bus.stall_cnt = cnt_q;
endmodule
